// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the fetch stage: next-PC ops, FSM states and the
// default bubble instruction.
package fetch_stage_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b011;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: a request is accepted in any cycle imem_req is high (no ready);
// exactly one request may be outstanding and its single response is flagged
// by imem_rvalid for one cycle, carrying the word in imem_rdata.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_rvalid, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/fetch_stage_npc_calc.sv
// Combinational next-PC resolution for the instruction in EX: taken flag and
// redirect target. Codes other than branch/jump/jalr behave as PC+4.
module npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [2:0]  npc_op,
  input  logic        zero,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = 1'b0;
    target   = pc + imm;
    case (npc_op)
      NPC_BRANCH: redirect = zero;
      NPC_JUMP:   redirect = 1'b1;
      NPC_JALR: begin
        redirect = 1'b1;
        target   = alu_out & ~32'h1;
      end
      default:    redirect = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM
// with stale-response dropping, and the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        write_PC,
  input  logic        write_IFID,
  input  logic        flush_IFID,
  input  logic [2:0]  NPCOp_IDEX,
  input  logic        Zero,
  input  logic [31:0] PC_IDEX,
  input  logic [31:0] imm_IDEX,
  input  logic [31:0] aluout_EX,
  fetch_stage_if.master bus,
  output logic [31:0] PC_IFID,
  output logic [31:0] instr_IFID,
  output logic        valid_IFID,
  output logic [31:0] fetch_bubbles,
  output logic [1:0]  dbg_state
);

  logic        redirect;
  logic [31:0] target;
  logic        adv;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, hold_q, hold_d, seq_pc;
  logic        req_raw;
  logic [31:0] addr_raw;
  logic        deliver;
  logic [31:0] deliver_instr;

  npc_calc u_npc_calc (
    .npc_op   (NPCOp_IDEX),
    .zero     (Zero),
    .pc       (PC_IDEX),
    .imm      (imm_IDEX),
    .alu_out  (aluout_EX),
    .redirect (redirect),
    .target   (target)
  );

  assign adv       = write_PC && write_IFID;
  assign seq_pc    = req_pc_q + 32'd4;
  assign dbg_state = state_q;

  // A redirect always wins over advance; any response to a request issued
  // before the redirect is discarded, either directly or via S_DROP.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    hold_d        = hold_q;
    req_raw       = 1'b0;
    addr_raw      = pc_q;
    deliver       = 1'b0;
    deliver_instr = hold_q;
    case (state_q)
      S_REQ: begin
        req_raw  = 1'b1;
        req_pc_d = pc_q;
        state_d  = S_WAIT;
        if (redirect) begin
          pc_d    = target;
          state_d = S_DROP;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          if (redirect) begin
            req_raw  = 1'b1;
            addr_raw = target;
            req_pc_d = target;
            pc_d     = target;
          end else if (adv) begin
            deliver       = 1'b1;
            deliver_instr = bus.imem_rdata;
            req_raw       = 1'b1;
            addr_raw      = seq_pc;
            req_pc_d      = seq_pc;
            pc_d          = seq_pc;
          end else begin
            hold_d  = bus.imem_rdata;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          pc_d    = target;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (adv) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          pc_d          = seq_pc;
          state_d       = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = target;
        if (bus.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  assign bus.imem_req  = req_raw && !rst;
  assign bus.imem_addr = {addr_raw[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      hold_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_IFID       <= 32'h0;
      instr_IFID    <= NOP_INSTR;
      valid_IFID    <= 1'b0;
      fetch_bubbles <= 32'h0;
    end else if (flush_IFID || redirect) begin
      valid_IFID <= 1'b0;
      instr_IFID <= NOP_INSTR;
    end else if (write_IFID) begin
      if (deliver) begin
        PC_IFID    <= req_pc_q;
        instr_IFID <= deliver_instr;
        valid_IFID <= 1'b1;
      end else begin
        valid_IFID    <= 1'b0;
        instr_IFID    <= NOP_INSTR;
        fetch_bubbles <= fetch_bubbles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect traffic against a program-order reference model.
`timescale 1ns/1ps
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_PC, write_IFID, flush_IFID, Zero;
  logic [2:0]  NPCOp_IDEX;
  logic [31:0] PC_IDEX, imm_IDEX, aluout_EX;
  logic [31:0] PC_IFID, instr_IFID, fetch_bubbles;
  logic        valid_IFID;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] exp_q[$];

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .write_PC      (write_PC),
    .write_IFID    (write_IFID),
    .flush_IFID    (flush_IFID),
    .NPCOp_IDEX    (NPCOp_IDEX),
    .Zero          (Zero),
    .PC_IDEX       (PC_IDEX),
    .imm_IDEX      (imm_IDEX),
    .aluout_EX     (aluout_EX),
    .bus           (bus),
    .PC_IFID       (PC_IFID),
    .instr_IFID    (instr_IFID),
    .valid_IFID    (valid_IFID),
    .fetch_bubbles (fetch_bubbles),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ a[15:0] ^ 16'h0F0F};
  endfunction

  // Memory with programmable latency; the response appears mem_lat cycles
  // after the request cycle. Reset by the same rst as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt         <= 0;
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= 32'h0;
    end else begin
      bus.imem_rvalid <= 1'b0;
      if (bus.imem_req) begin
        if (mem_lat == 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem_word(bus.imem_addr);
          mem_cnt         <= 0;
        end else begin
          mem_cnt  <= mem_lat - 1;
          mem_addr <= bus.imem_addr;
        end
      end else if (mem_cnt != 0) begin
        if (mem_cnt == 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem_word(mem_addr);
        end
        mem_cnt <= mem_cnt - 1;
      end
    end
  end

  // ---------------- reference rules ----------------
  function automatic logic model_taken(input logic [2:0] op, input logic z);
    return (op == NPC_JUMP) || (op == NPC_JALR) || (op == NPC_BRANCH && z);
  endfunction

  function automatic logic [31:0] model_target(input logic [2:0] op, input logic [31:0] pc,
                                               input logic [31:0] imm, input logic [31:0] alu);
    if (op == NPC_JALR) return {alu[31:1], 1'b0};
    return pc + imm;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_PC   = 1'b1;
    write_IFID = 1'b1;
    flush_IFID = 1'b0;
    NPCOp_IDEX = NPC_PLUS4;
    Zero       = 1'b0;
    PC_IDEX    = 32'h0;
    imm_IDEX   = 32'h0;
    aluout_EX  = 32'h0;
  endtask

  task automatic drive_redirect(input logic [2:0] op, input logic z, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [31:0] alu);
    NPCOp_IDEX = op;
    Zero       = z;
    PC_IDEX    = pc;
    imm_IDEX   = imm;
    aluout_EX  = alu;
    flush_IFID = model_taken(op, z);
  endtask

  task automatic do_reset(input int lat);
    mem_lat = lat;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (PC_IFID !== 32'h0) begin errors++; $display("FAIL reset_pc_ifid: got %h want 0", PC_IFID); end
    checks++; if (instr_IFID !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instr_IFID, NOP); end
    checks++; if (valid_IFID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_IFID); end
    checks++; if (fetch_bubbles !== 32'h0) begin errors++; $display("FAIL reset_bubbles: got %0d want 0", fetch_bubbles); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    do_reset(1);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
    for (int c = 0; c < 4; c++) begin
      e = exp_q.pop_front();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== e) begin
        errors++; $display("FAIL b2b_req c%0d: got req=%b addr=%h want req=1 addr=%h", c, bus.imem_req, bus.imem_addr, e); end
      if (c >= 2) begin
        e = RESET_PC + 32'(4 * (c - 2));
        checks++; if (valid_IFID !== 1'b1 || PC_IFID !== e || instr_IFID !== mem_word(e)) begin
          errors++; $display("FAIL b2b_ifid c%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", c, valid_IFID, PC_IFID, instr_IFID, e, mem_word(e)); end
        checks++; if (fetch_bubbles !== 32'd1) begin errors++; $display("FAIL b2b_bubbles: got %0d want 1", fetch_bubbles); end
      end
      step();
    end
  endtask

  task automatic test_load_use();
    do_reset(1);
    step(); step(); step();
    write_PC = 1'b0; write_IFID = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL lu_no_req: got %b want 0", bus.imem_req); end
    step();
    checks++; if (dbg_state !== S_HOLD) begin errors++; $display("FAIL lu_state: got %0d want %0d", dbg_state, S_HOLD); end
    checks++; if (PC_IFID !== 32'h4 || valid_IFID !== 1'b1) begin
      errors++; $display("FAIL lu_hold: got pc=%h v=%b want pc=4 v=1", PC_IFID, valid_IFID); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL lu_hold_req: got %b want 0", bus.imem_req); end
    write_PC = 1'b1; write_IFID = 1'b1;
    step();
    checks++; if (PC_IFID !== 32'h8 || instr_IFID !== mem_word(32'h8) || valid_IFID !== 1'b1) begin
      errors++; $display("FAIL lu_release: got pc=%h i=%h v=%b want pc=8 i=%h v=1", PC_IFID, instr_IFID, valid_IFID, mem_word(32'h8)); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
      errors++; $display("FAIL lu_next_req: got req=%b addr=%h want req=1 addr=c", bus.imem_req, bus.imem_addr); end
    checks++; if (fetch_bubbles !== 32'd1) begin errors++; $display("FAIL lu_bubbles: got %0d want 1", fetch_bubbles); end
  endtask

  task automatic test_branch_taken();
    do_reset(1);
    step();
    drive_redirect(NPC_BRANCH, 1'b1, 32'h10, 32'h20, 32'h0);
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h30) begin
      errors++; $display("FAIL br_req: got req=%b addr=%h want req=1 addr=30", bus.imem_req, bus.imem_addr); end
    step();
    idle_inputs();
    #1;
    checks++; if (valid_IFID !== 1'b0 || instr_IFID !== NOP) begin
      errors++; $display("FAIL br_flush: got v=%b i=%h want v=0 i=%h", valid_IFID, instr_IFID, NOP); end
    checks++; if (fetch_bubbles !== 32'd1) begin errors++; $display("FAIL br_bubbles: got %0d want 1", fetch_bubbles); end
    step();
    checks++; if (valid_IFID !== 1'b1 || PC_IFID !== 32'h30 || instr_IFID !== mem_word(32'h30)) begin
      errors++; $display("FAIL br_target: got v=%b pc=%h i=%h want v=1 pc=30 i=%h", valid_IFID, PC_IFID, instr_IFID, mem_word(32'h30)); end
  endtask

  task automatic test_branch_not_taken();
    do_reset(1);
    step();
    drive_redirect(NPC_BRANCH, 1'b0, 32'h10, 32'h20, 32'h0);
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      errors++; $display("FAIL bnt_req: got req=%b addr=%h want req=1 addr=4", bus.imem_req, bus.imem_addr); end
    step();
    idle_inputs();
    #1;
    checks++; if (valid_IFID !== 1'b1 || PC_IFID !== 32'h0) begin
      errors++; $display("FAIL bnt_ifid: got v=%b pc=%h want v=1 pc=0", valid_IFID, PC_IFID); end
    step();
    checks++; if (valid_IFID !== 1'b1 || PC_IFID !== 32'h4) begin
      errors++; $display("FAIL bnt_seq: got v=%b pc=%h want v=1 pc=4", valid_IFID, PC_IFID); end
  endtask

  task automatic test_jalr_drop();
    int n;
    do_reset(3);
    step();
    drive_redirect(NPC_JALR, 1'b0, 32'h0, 32'h0, 32'h41);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL jalr_no_req: got %b want 0", bus.imem_req); end
    step();
    idle_inputs();
    #1;
    checks++; if (valid_IFID !== 1'b0) begin errors++; $display("FAIL jalr_flush: got %b want 0", valid_IFID); end
    n = 0;
    while (!bus.imem_req && n < 10) begin
      checks++; if (valid_IFID !== 1'b0) begin errors++; $display("FAIL jalr_stale_delivery: got pc=%h want none", PC_IFID); end
      step(); n++;
    end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      errors++; $display("FAIL jalr_req: got req=%b addr=%h want req=1 addr=40", bus.imem_req, bus.imem_addr); end
    n = 0;
    while (!valid_IFID && n < 10) begin step(); n++; end
    checks++; if (valid_IFID !== 1'b1 || PC_IFID !== 32'h40 || instr_IFID !== mem_word(32'h40)) begin
      errors++; $display("FAIL jalr_target: got v=%b pc=%h i=%h want v=1 pc=40 i=%h", valid_IFID, PC_IFID, instr_IFID, mem_word(32'h40)); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(3);
    step();
    drive_redirect(NPC_JUMP, 1'b0, 32'h20, 32'h4, 32'h0);
    step();
    idle_inputs();
    #1;
    n = 0;
    while (!bus.imem_req && n < 10) begin step(); n++; end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24) begin
      errors++; $display("FAIL rm_req24: got req=%b addr=%h want req=1 addr=24", bus.imem_req, bus.imem_addr); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || valid_IFID !== 1'b0 || PC_IFID !== 32'h0 || instr_IFID !== NOP || fetch_bubbles !== 32'h0) begin
      errors++; $display("FAIL rm_async: got req=%b v=%b pc=%h i=%h bub=%0d want 0/0/0/%h/0", bus.imem_req, valid_IFID, PC_IFID, instr_IFID, fetch_bubbles, NOP); end
    checks++; if (dbg_state !== S_REQ) begin errors++; $display("FAIL rm_state: got %0d want %0d", dbg_state, S_REQ); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      errors++; $display("FAIL rm_restart: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC); end
    n = 0;
    while (!valid_IFID && n < 10) begin step(); n++; end
    checks++; if (valid_IFID !== 1'b1 || PC_IFID !== RESET_PC) begin
      errors++; $display("FAIL rm_first: got v=%b pc=%h want v=1 pc=%h", valid_IFID, PC_IFID, RESET_PC); end
  endtask

  // Random stalls and redirects; delivered instructions must follow program
  // order from the latest redirect target, one word per delivery.
  task automatic test_random(input int lat, input int cycles);
    logic [31:0] next_pc, exp_bub, prev_pc, prev_instr, tgt;
    logic        prev_valid, tk;
    int          delivered, r;
    do_reset(lat);
    next_pc = RESET_PC; exp_bub = 0; delivered = 0;
    for (int c = 0; c < cycles; c++) begin
      r = $urandom_range(0, 99);
      write_PC   = ($urandom_range(0, 99) < 80);
      write_IFID = ($urandom_range(0, 3) != 0) ? write_PC : ~write_PC;
      Zero       = 1'($urandom_range(0, 1));
      if (r < 6)       NPCOp_IDEX = NPC_BRANCH;
      else if (r < 9)  NPCOp_IDEX = NPC_JUMP;
      else if (r < 11) NPCOp_IDEX = NPC_JALR;
      else if (r < 14) NPCOp_IDEX = 3'($urandom_range(4, 7));
      else             NPCOp_IDEX = NPC_PLUS4;
      PC_IDEX    = (r % 5 == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'h0000_0FFC);
      imm_IDEX   = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
      aluout_EX  = $urandom() & 32'h0000_0FFD;
      tk         = model_taken(NPCOp_IDEX, Zero);
      tgt        = model_target(NPCOp_IDEX, PC_IDEX, imm_IDEX, aluout_EX);
      flush_IFID = tk;
      prev_pc = PC_IFID; prev_instr = instr_IFID; prev_valid = valid_IFID;
      #1;
      if (bus.imem_req) begin
        checks++; if (bus.imem_addr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align: got %h want aligned", bus.imem_addr); end
      end
      step();
      if (tk) begin
        checks++; if (valid_IFID !== 1'b0 || instr_IFID !== 32'h0000_0013) begin
          errors++; $display("FAIL rnd_flush c%0d: got v=%b i=%h want v=0 i=13", c, valid_IFID, instr_IFID); end
        next_pc = tgt;
      end else if (!write_IFID) begin
        checks++; if (PC_IFID !== prev_pc || instr_IFID !== prev_instr || valid_IFID !== prev_valid) begin
          errors++; $display("FAIL rnd_hold c%0d: got pc=%h i=%h v=%b want pc=%h i=%h v=%b", c, PC_IFID, instr_IFID, valid_IFID, prev_pc, prev_instr, prev_valid); end
      end else if (valid_IFID) begin
        checks++; if (PC_IFID !== next_pc || instr_IFID !== mem_word(next_pc) || !write_PC) begin
          errors++; $display("FAIL rnd_deliver c%0d: got pc=%h i=%h wpc=%b want pc=%h i=%h wpc=1", c, PC_IFID, instr_IFID, write_PC, next_pc, mem_word(next_pc)); end
        next_pc = next_pc + 32'd4;
        delivered++;
      end else begin
        checks++; if (instr_IFID !== 32'h0000_0013) begin errors++; $display("FAIL rnd_bubble c%0d: got %h want 13", c, instr_IFID); end
        exp_bub = exp_bub + 32'd1;
      end
      checks++; if (fetch_bubbles !== exp_bub) begin
        errors++; $display("FAIL rnd_bubbles c%0d: got %0d want %0d", c, fetch_bubbles, exp_bub); end
    end
    checks++; if (delivered < 20) begin errors++; $display("FAIL rnd_progress lat%0d: got %0d deliveries want >=20", lat, delivered); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch_taken();
    test_branch_not_taken();
    test_jalr_drop();
    test_reset_mid();
    test_random(1, 300);
    test_random(2, 300);
    test_random(4, 300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
